// File: rtl/upsizer_pkg.sv
// ---------------------------------------------------------------------------
// upsizer_pkg
// Shared definitions for the upsizer stream arbiter slice.
//   state_t   : arbiter FSM states (IDLE, ARB, XFER)
//   src_width : width of a source index for a given requester count
// ---------------------------------------------------------------------------
package upsizer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } state_t;

   // A single requester still needs one index bit to keep ports non-empty.
   function automatic int src_width(input int n_src);
      if (n_src <= 1) begin
         return 1;
      end else begin
         return $clog2(n_src);
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Picks the first requesting
// source starting at (last_grant + 1) mod N_SRC and wrapping upward.
// Ports:
//   req        in  [N_SRC]  request vector
//   last_grant in  [SRC_W]  index granted most recently
//   grant      out [SRC_W]  selected index (0 when no request)
//   any_req    out 1        at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter
   import upsizer_pkg::*;
#(
   parameter  int N_SRC = 4,
   localparam int SRC_W = src_width(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SRC_W-1:0] last_grant,
   output logic [SRC_W-1:0] grant,
   output logic             any_req
);

   logic found_s;
   int   idx_s;

   // Rotating priority search; the first hit after last_grant wins.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int i = 1; i <= N_SRC; i++) begin
         idx_s = (int'(last_grant) + i) % N_SRC;
         if (!found_s && req[idx_s]) begin
            grant   = SRC_W'(idx_s);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/upsizer_stream_arbiter.sv
// ---------------------------------------------------------------------------
// upsizer_stream_arbiter
// Packet-granular round-robin arbiter feeding a width upsizer. A grant is
// held for a whole packet; packets longer than MAX_BEATS are cut with a
// forced last and the sticky err_trunc_o flag. Output beat is registered.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   s_data_i      per-source beat data
//   s_valid_i     per-source valid
//   s_last_i      per-source end-of-packet
//   s_ready_o     per-source ready (one-hot or zero)
//   m_data_o      registered beat toward the upsizer
//   m_valid_o     registered valid
//   m_last_o      registered last
//   m_ready_i     upsizer ready
//   m_src_o       source index of the beat in m_data_o
//   err_trunc_o   sticky packet-truncation flag
// ---------------------------------------------------------------------------
module upsizer_stream_arbiter
   import upsizer_pkg::*;
#(
   parameter  int T_DATA_WIDTH = 4,
   parameter  int N_SRC        = 4,
   parameter  int MAX_BEATS    = 16,
   localparam int SRC_W        = src_width(N_SRC),
   localparam int CNT_W        = $clog2(MAX_BEATS + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_SRC-1:0][T_DATA_WIDTH-1:0]   s_data_i,
   input  logic [N_SRC-1:0]                     s_valid_i,
   input  logic [N_SRC-1:0]                     s_last_i,
   output logic [N_SRC-1:0]                     s_ready_o,
   output logic [T_DATA_WIDTH-1:0]              m_data_o,
   output logic                                 m_valid_o,
   output logic                                 m_last_o,
   input  logic                                 m_ready_i,
   output logic [SRC_W-1:0]                     m_src_o,
   output logic                                 err_trunc_o
);

   state_t                    state_r;
   logic [SRC_W-1:0]          grant_r;
   logic [SRC_W-1:0]          last_grant_r;
   logic [CNT_W-1:0]          beat_cnt_r;
   logic [T_DATA_WIDTH-1:0]   m_data_r;
   logic                      m_valid_r;
   logic                      m_last_r;
   logic [SRC_W-1:0]          m_src_r;
   logic                      err_trunc_r;

   logic [SRC_W-1:0]          arb_grant_s;
   logic                      any_req_s;
   logic [N_SRC-1:0]          ready_s;
   logic [N_SRC-1:0]          grant_mask_s;
   logic                      out_free_s;
   logic                      accept_s;
   logic                      cap_s;
   logic                      pkt_end_s;
   logic                      other_req_s;

   rr_arbiter #(
      .N_SRC      (N_SRC)
   ) u_rr_arbiter (
      .req        (s_valid_i),
      .last_grant (last_grant_r),
      .grant      (arb_grant_s),
      .any_req    (any_req_s)
   );

   // Output register can take a beat when empty or draining this cycle.
   assign out_free_s = !m_valid_r || m_ready_i;
   assign accept_s   = (state_r == XFER) && s_valid_i[grant_r] && out_free_s;
   // The beat being accepted is number MAX_BEATS of the packet.
   assign cap_s      = (beat_cnt_r == CNT_W'(MAX_BEATS - 1));
   assign pkt_end_s  = accept_s && (s_last_i[grant_r] || cap_s);
   // Requests from other sources decide whether to re-arbitrate at once.
   assign other_req_s = |(s_valid_i & ~grant_mask_s);

   // One-hot mask of the current grant.
   always_comb begin
      grant_mask_s          = '0;
      grant_mask_s[grant_r] = 1'b1;
   end

   // Only the granted source sees ready, and only during XFER.
   always_comb begin
      ready_s = '0;
      if (state_r == XFER) begin
         ready_s[grant_r] = out_free_s;
      end else begin
         ready_s = '0;
      end
   end

   assign s_ready_o   = ready_s;
   assign m_data_o    = m_data_r;
   assign m_valid_o   = m_valid_r;
   assign m_last_o    = m_last_r;
   assign m_src_o     = m_src_r;
   assign err_trunc_o = err_trunc_r;

   // Arbitration FSM, beat counter and registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         grant_r      <= '0;
         last_grant_r <= SRC_W'(N_SRC - 1);
         beat_cnt_r   <= '0;
         m_data_r     <= '0;
         m_valid_r    <= 1'b0;
         m_last_r     <= 1'b0;
         m_src_r      <= '0;
         err_trunc_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            m_data_r  <= s_data_i[grant_r];
            m_last_r  <= s_last_i[grant_r] || cap_s;
            m_src_r   <= grant_r;
            m_valid_r <= 1'b1;
         end else if (m_ready_i) begin
            m_valid_r <= 1'b0;
         end else begin
            m_valid_r <= m_valid_r;
         end

         // A cut is an error only when the source did not end the packet itself.
         if (accept_s && cap_s && !s_last_i[grant_r]) begin
            err_trunc_r <= 1'b1;
         end else begin
            err_trunc_r <= err_trunc_r;
         end

         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  state_r <= ARB;
               end else begin
                  state_r <= IDLE;
               end
            end
            ARB: begin
               if (any_req_s) begin
                  grant_r    <= arb_grant_s;
                  beat_cnt_r <= '0;
                  state_r    <= XFER;
               end else begin
                  state_r    <= IDLE;
               end
            end
            XFER: begin
               if (pkt_end_s) begin
                  last_grant_r <= grant_r;
                  beat_cnt_r   <= '0;
                  state_r      <= other_req_s ? ARB : IDLE;
               end else if (accept_s) begin
                  beat_cnt_r   <= beat_cnt_r + CNT_W'(1);
               end else begin
                  beat_cnt_r   <= beat_cnt_r;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_upsizer_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_upsizer_stream_arbiter
// Directed scoreboard bench. Source queues model the requesters; expected
// output beats are pushed in hand-computed order and popped by a monitor
// whenever the DUT hands a beat to the (modelled) upsizer.
// ---------------------------------------------------------------------------
module tb_upsizer_stream_arbiter;

   localparam int TW = 8;
   localparam int NS = 4;
   localparam int MB = 4;
   localparam int SW = 2;
   localparam int BUDGET = 300;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NS-1:0][TW-1:0]  s_data_i;
   logic [NS-1:0]          s_valid_i;
   logic [NS-1:0]          s_last_i;
   logic [NS-1:0]          s_ready_o;
   logic [TW-1:0]          m_data_o;
   logic                   m_valid_o;
   logic                   m_last_o;
   logic                   m_ready_i;
   logic [SW-1:0]          m_src_o;
   logic                   err_trunc_o;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [TW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct packed {
      logic [TW-1:0] data;
      logic          last;
   } beat_t;

   exp_t   exp_q[$];
   beat_t  src_q[NS][$];
   int     n_checks = 0;
   int     n_pass   = 0;
   logic [NS-1:0] fire;
   logic   stall_prev = 1'b0;
   logic [31:0] held = 32'd0;

   upsizer_stream_arbiter #(
      .T_DATA_WIDTH (TW),
      .N_SRC        (NS),
      .MAX_BEATS    (MB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_last_i    (s_last_i),
      .s_ready_o   (s_ready_o),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_last_o    (m_last_o),
      .m_ready_i   (m_ready_i),
      .m_src_o     (m_src_o),
      .err_trunc_o (err_trunc_o)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic logic [31:0] out_word();
      return 32'({m_src_o, m_data_o, m_last_o});
   endfunction

   function automatic logic src_busy();
      logic b = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() != 0) b = 1'b1;
      end
      return b;
   endfunction

   task automatic push(input int s, input logic [TW-1:0] d, input logic l);
      src_q[s].push_back(beat_t'{data: d, last: l});
   endtask

   task automatic expect_beat(input int s, input logic [TW-1:0] d, input logic l);
      exp_q.push_back(exp_t'{src: SW'(s), data: d, last: l});
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((src_busy() || exp_q.size() != 0 || m_valid_o) && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_drain_timeout"}, 32'(cyc >= BUDGET), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      int cyc = 0;
      @(negedge clk);
      while (!m_valid_o && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_valid_timeout"}, 32'(cyc >= BUDGET), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NS; i++) src_q[i].delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Source model: pop a beat the cycle after its handshake, present the next.
   initial begin
      s_valid_i = '0;
      s_data_i  = '0;
      s_last_i  = '0;
      forever begin
         @(negedge clk);
         fire = s_valid_i & s_ready_o;
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0) begin
               s_valid_i[i] = 1'b1;
               s_data_i[i]  = src_q[i][0].data;
               s_last_i[i]  = src_q[i][0].last;
            end else begin
               s_valid_i[i] = 1'b0;
               s_data_i[i]  = '0;
               s_last_i[i]  = 1'b0;
            end
         end
      end
   end

   // Monitor: per-cycle handshake rules and scoreboard comparison.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("ready_onehot0", 32'($onehot0(s_ready_o)), 32'd1);
            if (m_valid_o && !m_ready_i) check("ready_low_while_stalled", 32'(s_ready_o), 32'd0);
            if (stall_prev && m_valid_o) check("stall_hold", out_word(), held);
            if (m_valid_o && m_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_beat: actual src %0d data %0h last %0b required none",
                           m_src_o, m_data_o, m_last_o);
               end else begin
                  check("beat", out_word(), 32'(exp_q.pop_front()));
               end
            end
         end
         stall_prev = m_valid_o && !m_ready_i;
         held       = out_word();
      end
   end

   // Directed scenarios.
   initial begin
      m_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_m_valid", 32'(m_valid_o), 32'd0);
      check("rst_m_last",  32'(m_last_o),  32'd0);
      check("rst_m_data",  32'(m_data_o),  32'd0);
      check("rst_m_src",   32'(m_src_o),   32'd0);
      check("rst_err",     32'(err_trunc_o), 32'd0);
      check("rst_s_ready", 32'(s_ready_o), 32'd0);
      rst = 1'b0;

      // All four sources, 2-beat packets: served 0,1,2,3.
      for (int s = 0; s < NS; s++) begin
         push(s, TW'(16 * s + 1), 1'b0);
         push(s, TW'(16 * s + 2), 1'b1);
      end
      for (int s = 0; s < NS; s++) begin
         expect_beat(s, TW'(16 * s + 1), 1'b0);
         expect_beat(s, TW'(16 * s + 2), 1'b1);
      end
      wait_drain("rr_order");

      // Source 2, A,B,C with back-pressure on output cycle 2.
      push(2, 8'hA1, 1'b0);
      push(2, 8'hB2, 1'b0);
      push(2, 8'hC3, 1'b1);
      expect_beat(2, 8'hA1, 1'b0);
      expect_beat(2, 8'hB2, 1'b0);
      expect_beat(2, 8'hC3, 1'b1);
      wait_valid("stall");
      @(posedge clk);
      #1 m_ready_i = 1'b0;
      @(negedge clk);
      check("stall_data_B", 32'(m_data_o), 32'h0000_00B2);
      check("stall_ready2", 32'(s_ready_o[2]), 32'd0);
      repeat (3) @(posedge clk);
      #1 m_ready_i = 1'b1;
      wait_drain("stall");

      // Single requester, two packets back-to-back.
      push(1, 8'h11, 1'b0);
      push(1, 8'h12, 1'b1);
      push(1, 8'h13, 1'b0);
      push(1, 8'h14, 1'b1);
      expect_beat(1, 8'h11, 1'b0);
      expect_beat(1, 8'h12, 1'b1);
      expect_beat(1, 8'h13, 1'b0);
      expect_beat(1, 8'h14, 1'b1);
      wait_drain("single_src");

      // Wrap-around: after reset source 0 first, then 3 beats 0's second packet.
      do_reset();
      push(0, 8'h0A, 1'b1);
      push(0, 8'h0B, 1'b1);
      push(3, 8'h3A, 1'b1);
      expect_beat(0, 8'h0A, 1'b1);
      expect_beat(3, 8'h3A, 1'b1);
      expect_beat(0, 8'h0B, 1'b1);
      wait_drain("wrap");

      // Truncation at MAX_BEATS=4 of a 6-beat packet.
      check("err_before_trunc", 32'(err_trunc_o), 32'd0);
      for (int b = 1; b <= 6; b++) push(0, TW'(8'h50 + b), 1'(b == 6));
      for (int b = 1; b <= 6; b++) expect_beat(0, TW'(8'h50 + b), 1'(b == 4 || b == 6));
      wait_drain("trunc");
      check("err_after_trunc", 32'(err_trunc_o), 32'd1);

      // Reset during beat 2 of a 4-beat packet.
      for (int b = 1; b <= 4; b++) push(0, TW'(8'h60 + b), 1'(b == 4));
      expect_beat(0, 8'h61, 1'b0);
      wait_valid("mid_rst");
      rst = 1'b1;
      for (int i = 0; i < NS; i++) src_q[i].delete();
      @(negedge clk);
      check("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
      check("mid_rst_s_ready", 32'(s_ready_o), 32'd0);
      check("mid_rst_err",     32'(err_trunc_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(1, 8'h7A, 1'b1);
      push(0, 8'h70, 1'b1);
      expect_beat(0, 8'h70, 1'b1);
      expect_beat(1, 8'h7A, 1'b1);
      wait_drain("post_rst");
      check("leftover_expected", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
